// File: rtl/write_through_buffer.sv
`default_nettype none
// ============================================================================
// Module      : write_through_buffer
// Description : Circular write-through buffer between a front-end write port
//               and a back-end write port. Optional write merging into the
//               newest entry is compiled in with the WTB_MERGE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module write_through_buffer #(
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int DEPTH_W   = 2,
    localparam int FE_NBYTES = FE_DATA_W / 8,
    localparam int FE_BYTE_W = $clog2(FE_NBYTES),
    localparam int WORD_A_W  = FE_ADDR_W - FE_BYTE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_valid,
    input  logic [WORD_A_W-1:0]  push_addr,
    input  logic [FE_DATA_W-1:0] push_wdata,
    input  logic [FE_NBYTES-1:0] push_wstrb,
    output logic                 push_ready,
    output logic                 write_valid,
    output logic [WORD_A_W-1:0]  write_addr,
    output logic [FE_DATA_W-1:0] write_wdata,
    output logic [FE_NBYTES-1:0] write_wstrb,
    input  logic                 write_ready,
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH_W:0]     level
);

    localparam int              c_ENTRIES = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] c_DEPTH  = {1'b1, {DEPTH_W{1'b0}}};

    logic [WORD_A_W-1:0]  r_addr_mem [0:c_ENTRIES-1];
    logic [FE_DATA_W-1:0] r_data_mem [0:c_ENTRIES-1];
    logic [FE_NBYTES-1:0] r_strb_mem [0:c_ENTRIES-1];

    logic [DEPTH_W-1:0] r_head;
    logic [DEPTH_W-1:0] r_tail;
    logic [DEPTH_W:0]   r_level;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_alloc;

    assign w_full  = (r_level == c_DEPTH);
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && write_ready;

`ifdef WTB_MERGE_EN
    localparam logic [DEPTH_W:0] c_TWO = (DEPTH_W + 1)'(2);

    logic [DEPTH_W-1:0] w_newest;
    logic               w_merge_hit;
    logic               w_merge;

    // The newest entry is only mergeable when it is not the head being presented.
    assign w_newest    = r_tail - 1'b1;
    assign w_merge_hit = (r_level >= c_TWO) && (r_addr_mem[w_newest] == push_addr);
    assign w_merge     = push_valid && w_merge_hit;
    assign w_alloc     = push_valid && !w_full && !w_merge_hit;
    assign push_ready  = !w_full || w_merge_hit;
`else
    assign w_alloc    = push_valid && !w_full;
    assign push_ready = !w_full;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_level <= r_level + {{DEPTH_W{1'b0}}, w_alloc} - {{DEPTH_W{1'b0}}, w_pop};
        end
    end

    // Storage is not reset; contents are only observed while write_valid is high.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr_mem[r_tail] <= push_addr;
            r_data_mem[r_tail] <= push_wdata;
            r_strb_mem[r_tail] <= push_wstrb;
        end
`ifdef WTB_MERGE_EN
        if (w_merge) begin
            for (int b = 0; b < FE_NBYTES; b++) begin
                if (push_wstrb[b]) begin
                    r_data_mem[w_newest][b*8 +: 8] <= push_wdata[b*8 +: 8];
                end
            end
            r_strb_mem[w_newest] <= r_strb_mem[w_newest] | push_wstrb;
        end
`endif
    end

    assign write_valid = !w_empty;
    assign write_addr  = r_addr_mem[r_head];
    assign write_wdata = r_data_mem[r_head];
    assign write_wstrb = r_strb_mem[r_head];
    assign empty       = w_empty;
    assign full        = w_full;
    assign level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_write_through_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_through_buffer
// Description : Self-checking bench for write_through_buffer; a queue-based
//               reference model feeds a scoreboard checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_through_buffer;

    localparam int c_DEPTH = 4;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [29:0] push_addr;
    logic [31:0] push_wdata;
    logic [3:0]  push_wstrb;
    logic        push_ready;
    logic        write_valid;
    logic [29:0] write_addr;
    logic [31:0] write_wdata;
    logic [3:0]  write_wstrb;
    logic        write_ready;
    logic        empty;
    logic        full;
    logic [2:0]  level;

    entry_t sb[$];
    int     m_level;
    int     checks;
    int     failures;

    write_through_buffer #(
        .FE_ADDR_W (32),
        .FE_DATA_W (32),
        .DEPTH_W   (2)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_addr   (push_addr),
        .push_wdata  (push_wdata),
        .push_wstrb  (push_wstrb),
        .push_ready  (push_ready),
        .write_valid (write_valid),
        .write_addr  (write_addr),
        .write_wdata (write_wdata),
        .write_wstrb (write_wstrb),
        .write_ready (write_ready),
        .empty       (empty),
        .full        (full),
        .level       (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, check status against the model, advance the model.
    task automatic step(input logic pv, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic wr);
        logic   exp_full;
        logic   hit;
        logic   pop;
        entry_t e;
        @(negedge clk);
        push_valid  = pv;
        push_addr   = a;
        push_wdata  = d;
        push_wstrb  = s;
        write_ready = wr;
        #1;
        exp_full = (m_level == c_DEPTH);
        hit      = 1'b0;
`ifdef WTB_MERGE_EN
        if (m_level >= 2 && sb.size() > 0) begin
            if (sb[sb.size()-1].addr == a) hit = 1'b1;
        end
`endif
        chk("push_ready", 64'(push_ready), 64'(!exp_full || hit));
        chk("write_valid", 64'(write_valid), 64'(m_level != 0));
        chk("level", 64'(level), 64'(m_level));
        chk("empty", 64'(empty), 64'(m_level == 0));
        chk("full", 64'(full), 64'(exp_full));
        pop = (m_level != 0) && wr;
        if (pv && hit) begin
            e = sb[sb.size()-1];
            for (int b = 0; b < 4; b++) begin
                if (s[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
            end
            e.strb = e.strb | s;
            sb[sb.size()-1] = e;
        end else if (pv && !exp_full) begin
            e.addr = a;
            e.data = d;
            e.strb = s;
            sb.push_back(e);
            m_level++;
        end
        if (pop) m_level--;
    endtask

    // Monitor: whenever the DUT presents an entry it must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && write_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual=valid required=no_entry at %0t", $time);
                end else begin
                    chk("write_addr", 64'(write_addr), 64'(sb[0].addr));
                    chk("write_wdata", 64'(write_wdata), 64'(sb[0].data));
                    chk("write_wstrb", 64'(write_wstrb), 64'(sb[0].strb));
                    if (write_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        checks      = 0;
        failures    = 0;
        m_level     = 0;
        reset       = 1'b0;
        push_valid  = 1'b0;
        push_addr   = '0;
        push_wdata  = '0;
        push_wstrb  = '0;
        write_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single push into an empty buffer, then held while the back end stalls.
        step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
        step(1'b1, 30'h10, 32'hAABBCCDD, 4'hF, 1'b0);
        repeat (5) step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
        repeat (2) step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1);

        // Fill to full, refuse a fifth push, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 30'(30'h40 + i), 32'(32'h1000 + i), 4'hF, 1'b0);
        repeat (6) step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1);

        // Simultaneous push and pop at level 2 across pointer wrap.
        step(1'b1, 30'h100, 32'h11, 4'h3, 1'b0);
        step(1'b1, 30'h101, 32'h22, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 30'(30'h102 + i), 32'($urandom), 4'(i), 1'b1);
        repeat (3) step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1);

        // Asynchronous reset in the middle of a cycle at level 3.
        for (int i = 0; i < 3; i++) step(1'b1, 30'(30'h200 + i), 32'(i), 4'hF, 1'b0);
        step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_write_valid", 64'(write_valid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_push_ready", 64'(push_ready), 64'(1));
        sb.delete();
        m_level = 0;
        @(negedge clk);
        reset = 1'b1;

        // Same-address push onto the newest entry (merges only when compiled in).
        step(1'b1, 30'h20, 32'h01020304, 4'hF, 1'b0);
        step(1'b1, 30'h24, 32'h05060708, 4'h6, 1'b0);
        step(1'b1, 30'h24, 32'h000000EE, 4'h1, 1'b0);
        step(1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
`ifdef WTB_MERGE_EN
        chk("merge_level", 64'(level), 64'(2));
`else
        chk("merge_level", 64'(level), 64'(3));
`endif
        repeat (5) step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1);

        // Random traffic with a small address space to exercise merging.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom), 30'($urandom_range(0, 3)), 32'($urandom),
                 4'($urandom), 1'($urandom));
        end
        repeat (8) step(1'b0, 30'h0, 32'h0, 4'h0, 1'b1);
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
